// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
//   Serial-in / parallel-out deserializer. Collects WIDTH serial bits under a
//   valid/ready handshake and presents each completed word on a held output
//   slot with its own valid/ready handshake toward the parallel stage. The
//   shift register and output register are separate, so the next word can be
//   collected while the previous one waits to be consumed. A start-of-frame
//   flag resynchronises word boundaries and reports a dropped partial word.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   ser_in     in   1      serial data bit
//   ser_valid  in   1      ser_in / ser_sof valid this cycle
//   ser_sof    in   1      this bit is bit 0 of a new word (qualified by ser_valid)
//   ser_ready  out  1      serial bit is accepted this cycle
//   par_out    out  WIDTH  assembled word (held while par_valid & ~par_ready)
//   par_valid  out  1      par_out holds an unconsumed word
//   par_ready  in   1      downstream consumes par_out this cycle
//   frame_err  out  1      one-cycle pulse: sof arrived mid-word, partial dropped
// -----------------------------------------------------------------------------
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             ser_sof,
    output logic             ser_ready,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             frame_err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_par_out;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_frame_err;

    logic              w_acc;
    logic              w_done;
    logic [CW-1:0]     w_idx;
    logic [WIDTH-1:0]  w_base;
    logic [WIDTH-1:0]  w_shift_next;

    // A start-of-frame bit is always treated as index 0, whatever the counter says.
    assign w_idx  = ser_sof ? '0 : r_bit_cnt;
    assign w_base = ser_sof ? '0 : r_shift;

    // Only the completing bit can stall: it needs the output slot to be free
    // (empty, or being drained in this very cycle).
    assign ser_ready = ~((r_bit_cnt == LAST_IDX) & ~ser_sof & par_valid & ~par_ready);
    assign w_acc     = ser_valid & ser_ready;
    assign w_done    = w_acc & (w_idx == LAST_IDX);

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shift_next = {w_base[WIDTH-2:0], ser_in};
        end else begin : g_lsb_first
            assign w_shift_next = {ser_in, w_base[WIDTH-1:1]};
        end
    endgenerate

    // Serial side: shift register, bit counter, framing error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_acc & ser_sof & (r_bit_cnt != '0);
            if (w_acc) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= w_done ? '0 : (w_idx + CW'(1));
            end
        end
    end

    // Output slot data: loads only on completion, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_out <= '0;
        end else if (w_done) begin
            r_par_out <= w_shift_next;
        end
    end

    // Output slot occupancy FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_done) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                // A completion while FULL only happens when the old word is
                // being consumed in the same cycle: the slot stays full.
                if (par_ready && !w_done) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    assign par_valid = (r_state == FULL);
    assign par_out   = r_par_out;
    assign frame_err = r_frame_err;

endmodule
